// File: rtl/row_array_ctrl.sv
// 8x8 playfield row store: sequenced clear, row writes from the game FSM with a
// one-deep pending buffer, registered debug readback and a divided row-scan readout.
module row_array_ctrl #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned ROWS     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] wr_val,
   input  logic [2:0] wr_row,
   input  logic       wr_strobe,
   input  logic       clr_req,
   output logic       busy,
   input  logic [2:0] rd_row,
   output logic [7:0] rd_data,
   output logic [7:0] scan_row_sel,
   output logic [7:0] scan_cols,
   output logic       scan_tick
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

   state_t           state;
   logic [2:0]       clr_cnt;
   logic [7:0]       arr [ROWS];
   logic             pending_valid;
   logic [2:0]       pending_row;
   logic [7:0]       pending_val;
   logic [2:0]       scan_idx;
   logic [DIV_W-1:0] div_cnt;
   logic             clear_next;

   // Whether the next cycle is a clear cycle; busy and row blanking both follow
   // it so the matrix is dark for exactly the cycles busy is high.
   always_comb begin
      clear_next = clr_req;
      if (state == CLEAR && clr_cnt != 3'd7)
         clear_next = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < ROWS; i++)
            arr[i] <= '0;
         state         <= IDLE;
         clr_cnt       <= '0;
         busy          <= 1'b0;
         pending_valid <= 1'b0;
         pending_row   <= '0;
         pending_val   <= '0;
         scan_idx      <= '0;
         div_cnt       <= '0;
         scan_row_sel  <= 8'b0000_0001;
         scan_cols     <= '0;
         scan_tick     <= 1'b0;
         rd_data       <= '0;
      end else begin
         state <= clear_next ? CLEAR : IDLE;
         busy  <= clear_next;

         if (state == IDLE) begin
            if (clr_req) begin
               clr_cnt <= '0;
               if (wr_strobe) begin
                  pending_val   <= wr_val;
                  pending_row   <= wr_row;
                  pending_valid <= 1'b1;
               end
            end else begin
               // Pending entry goes first so a same-row strobe overrides it.
               if (pending_valid) begin
                  arr[pending_row] <= pending_val;
                  pending_valid    <= 1'b0;
               end
               if (wr_strobe)
                  arr[wr_row] <= wr_val;
            end
         end else begin
            arr[clr_cnt] <= '0;
            clr_cnt      <= clr_req ? 3'd0 : clr_cnt + 3'd1;
            if (wr_strobe) begin
               pending_val   <= wr_val;
               pending_row   <= wr_row;
               pending_valid <= 1'b1;
            end
         end

         if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
            div_cnt   <= '0;
            scan_idx  <= scan_idx + 3'd1;
            scan_tick <= 1'b1;
         end else begin
            div_cnt   <= div_cnt + DIV_W'(1);
            scan_tick <= 1'b0;
         end

         scan_row_sel <= clear_next ? 8'h00 : (8'd1 << scan_idx);
         scan_cols    <= arr[scan_idx];
         rd_data      <= arr[rd_row];
      end
   end

endmodule

// File: doc/row_array_ctrl.md
Name: row_array_ctrl

Overview:
- Owns the 8x8 playfield row array that the game state machine writes into.
- Sequences three things on that storage: clear requests, row writes from the game FSM, and a continuous row-scan readout to the LED matrix.
- Sits between the game FSM outputs (val, rowIndex, writeStrobe, clrarray) and the matrix driver pins.
- Provides a registered readback port for debug and seven-segment use.

Parameters:
SCAN_DIV, 50000, clk cycles per displayed row (must be >= 2)
ROWS, 8, number of rows (fixed 8; sizes the 3-bit row index)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
wr_val  input  8  row pattern to store
wr_row  input  3  target row index
wr_strobe  input  1  write request, one-cycle qualified
clr_req  input  1  request to clear the whole array
busy  output  1  high while a clear sequence runs
rd_row  input  3  readback row select
rd_data  output  8  registered readback of array[rd_row]
scan_row_sel  output  8  one-hot active-high matrix row enable
scan_cols  output  8  column pattern for the selected row
scan_tick  output  1  one-cycle pulse on each scan row advance

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values:
  - all 8 array rows = 0
  - state = IDLE, clr_cnt = 0, busy = 0
  - pending_valid = 0
  - scan_idx = 0, div_cnt = 0
  - scan_row_sel = 8'b00000001, scan_cols = 0, scan_tick = 0, rd_data = 0
- A reset mid-clear or mid-scan aborts immediately to the reset values.
- State IDLE:
  - wr_strobe & ~clr_req: array[wr_row] <= wr_val at this edge.
  - clr_req: go to CLEAR, clr_cnt <= 0, busy <= 1.
  - clr_req and wr_strobe in the same cycle: clear wins; the write is captured into the pending buffer (pending_val, pending_row, pending_valid <= 1).
- State CLEAR:
  - Each cycle, array[clr_cnt] <= 0 and clr_cnt increments.
  - At clr_cnt == 7, go to IDLE and busy <= 0. busy is high for exactly 8 cycles.
  - wr_strobe during CLEAR is captured into the pending buffer. A later strobe overwrites the buffer (latest wins, one entry deep).
  - clr_req during CLEAR restarts clr_cnt at 0. The pending buffer is kept.
- Pending drain:
  - On the first IDLE cycle after CLEAR with pending_valid = 1, write the pending entry and clear pending_valid.
  - If wr_strobe is also high that cycle, write the pending entry first, then the new strobe in the same edge; the new strobe wins if the rows match.
  - If clr_req is also high that cycle, do not drain; re-enter CLEAR and keep pending.
- Readback: rd_data <= array[rd_row] every cycle, one-cycle latency, read-before-write (a same-edge write is not visible until the following cycle).
- Scan divider:
  - div_cnt counts 0..SCAN_DIV-1.
  - At the terminal count: div_cnt <= 0, scan_idx <= scan_idx + 1 (7 wraps to 0), scan_tick <= 1 for one cycle.
- Scan outputs:
  - scan_row_sel <= one-hot(scan_idx) except during CLEAR, where it is 0 (blanked).
  - scan_cols <= array[scan_idx] every cycle (one-cycle latency; new writes show on the next cycle).
  - The divider keeps running during CLEAR.
- Out-of-range: none possible; all indices are 3 bits.

Test Plan:
- Reset, then write wr_row=3, wr_val=8'hE0 -> rd_row=3 gives rd_data=8'hE0 two cycles after the strobe; rows 0-2 and 4-7 read 0.
- Fill all rows with 8'hFF, pulse clr_req -> busy high for exactly 8 cycles, scan_row_sel=0 during that window, then every row reads 0.
- During CLEAR, strobe row 5 = 8'h1C then row 6 = 8'h38 -> after busy falls, row 6 = 8'h38 and row 5 = 0 (latest wins).
- clr_req and wr_strobe (row 0, 8'h07) in the same IDLE cycle -> clear runs for 8 cycles, then row 0 = 8'h07.
- clr_req re-asserted at clr_cnt=4 -> busy stays high for 8 more cycles (13 total).
- SCAN_DIV=4, array row k = 1<<k -> scan_tick every 4 cycles; scan_row_sel steps 01,02,...,80,01 (wraps); scan_cols matches 1<<scan_idx; reset asserted mid-scan returns scan_row_sel to 01 asynchronously.
